// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct3 codes,
// FSM state encoding and the default datapath width.
package ex_muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// Combinational restoring-division slice: retires STEP quotient bits from
// (remainder, shifting dividend/quotient, divisor).
module div_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quot;

  // Remainder stays below the divisor, so the restored difference fits in XLEN bits.
  always_comb begin
    w_rem   = i_rem;
    w_quot  = i_quot;
    w_trial = '0;
    for (int unsigned k = 0; k < STEP; k++) begin
      w_trial = {w_rem, w_quot[XLEN-1]};
      w_quot  = {w_quot[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, i_div}) begin
        w_rem     = w_trial[XLEN-1:0] - i_div;
        w_quot[0] = 1'b1;
      end else begin
        w_rem = w_trial[XLEN-1:0];
      end
    end
  end

  assign o_rem  = w_rem;
  assign o_quot = w_quot;

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage; stalls the
// pipeline while busy and strobes done_o/wreg_o for one cycle with the result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic            wreg_o,
  output logic [4:0]      wd_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned NSTEP = XLEN / STEP;
  localparam int unsigned CW    = $clog2(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  funct3_e           r_f3;
  logic [4:0]        r_wd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag2;
  logic              r_s1, r_s2;
  logic [XLEN-1:0]   r_result;

  logic              w_s1, w_s2, w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_fast_res;
  logic [2*XLEN-1:0] w_mul_acc, w_acc_nxt, w_prod;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_div_rem, w_div_quot, w_quot_fix, w_rem_fix, w_final;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;

  assign w_s1   = op1_is_signed(funct3_i) && op1_i[XLEN-1];
  assign w_s2   = op2_is_signed(funct3_i) && op2_i[XLEN-1];
  assign w_mag1 = w_s1 ? -op1_i : op1_i;
  assign w_mag2 = w_s2 ? -op2_i : op2_i;

  assign w_div0 = funct3_i[2] && (op2_i == '0);
  assign w_ovf  = funct3_i[2] && !funct3_i[0] &&
                  (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign w_fast = w_div0 || w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div0)     w_fast_res = funct3_i[1] ? op1_i : '1;
    else if (w_ovf) w_fast_res = funct3_i[1] ? '0 : op1_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  assign stall_req_o = !rst && (w_accept || (r_state == S_CALC));
  assign done_o      = (r_state == S_DONE);
  assign wreg_o      = done_o;
  assign wd_o        = r_wd;
  assign result_o    = r_result;

  // Shift-add: multiplier sits in the low half of r_acc and shifts out as the
  // partial product grows into the high half.
  always_comb begin
    w_mul_acc = r_acc;
    w_mul_sum = '0;
    for (int unsigned k = 0; k < STEP; k++) begin
      w_mul_sum = {1'b0, w_mul_acc[2*XLEN-1:XLEN]} +
                  (w_mul_acc[0] ? {1'b0, r_mag2} : {(XLEN+1){1'b0}});
      w_mul_acc = {w_mul_sum, w_mul_acc[XLEN-1:1]};
    end
  end

  div_step #(.XLEN(XLEN), .STEP(STEP)) u_div_step (
    .i_rem  (r_acc[2*XLEN-1:XLEN]),
    .i_quot (r_acc[XLEN-1:0]),
    .i_div  (r_mag2),
    .o_rem  (w_div_rem),
    .o_quot (w_div_quot)
  );

  assign w_acc_nxt  = r_f3[2] ? {w_div_rem, w_div_quot} : w_mul_acc;
  assign w_prod     = (r_s1 ^ r_s2) ? -w_mul_acc : w_mul_acc;
  assign w_quot_fix = (r_s1 ^ r_s2) ? -w_div_quot : w_div_quot;
  assign w_rem_fix  = r_s1 ? -w_div_rem : w_div_rem;

  always_comb begin
    w_final = '0;
    unique case (r_f3)
      F3_MUL:                     w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            w_final = w_quot_fix;
      F3_REM, F3_REMU:            w_final = w_rem_fix;
      default:                    w_final = '0;
    endcase
  end

  // r_acc is {hi, lo} of the product for multiplies and {rem, quot} for divides;
  // both start as {0, |op1|}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_f3     <= F3_MUL;
      r_wd     <= '0;
      r_acc    <= '0;
      r_mag2   <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_f3   <= funct3_e'(funct3_i);
      r_wd   <= wd_i;
      r_acc  <= {{XLEN{1'b0}}, w_mag1};
      r_mag2 <= w_mag2;
      r_s1   <= w_s1;
      r_s2   <= w_s2;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LAST) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, random ops
// against an arithmetic reference model, and flush/reset/STEP=4 sequences.
module tb_ex_muldiv;

  localparam int LAT1 = 33;
  localparam int LAT4 = 9;

  logic        clk, rst;
  logic        a_start, a_flush, a_stall, a_done, a_wreg;
  logic [2:0]  a_f3;
  logic [31:0] a_op1, a_op2, a_res;
  logic [4:0]  a_wd, a_wdo;
  logic        b_start, b_flush, b_stall, b_done, b_wreg;
  logic [2:0]  b_f3;
  logic [31:0] b_op1, b_op2, b_res;
  logic [4:0]  b_wd, b_wdo;

  int n_chk = 0;
  int n_fail = 0;

  ex_muldiv #(.XLEN(32), .STEP(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(a_start), .funct3_i(a_f3), .op1_i(a_op1),
    .op2_i(a_op2), .wd_i(a_wd), .flush_i(a_flush), .stall_req_o(a_stall),
    .done_o(a_done), .wreg_o(a_wreg), .wd_o(a_wdo), .result_o(a_res)
  );

  ex_muldiv #(.XLEN(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(b_start), .funct3_i(b_f3), .op1_i(b_op1),
    .op2_i(b_op2), .wd_i(b_wd), .flush_i(b_flush), .stall_req_o(b_stall),
    .done_o(b_done), .wreg_o(b_wreg), .wd_o(b_wdo), .result_o(b_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic        g_done (input bit s); return s ? b_done  : a_done;  endfunction
  function automatic logic        g_stall(input bit s); return s ? b_stall : a_stall; endfunction
  function automatic logic        g_wreg (input bit s); return s ? b_wreg  : a_wreg;  endfunction
  function automatic logic [4:0]  g_wd   (input bit s); return s ? b_wdo   : a_wdo;   endfunction
  function automatic logic [31:0] g_res  (input bit s); return s ? b_res   : a_res;   endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return LAT1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd);
    if (sel) begin b_start = st; b_f3 = f3; b_op1 = a; b_op2 = b; b_wd = wd; end
    else     begin a_start = st; a_f3 = f3; a_op1 = a; a_op2 = b; a_wd = wd; end
  endtask

  task automatic run_op(input bit sel, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd,
                        output logic [31:0] res, output int lat);
    bit stall_ok;
    @(negedge clk);
    chk("done_single_cycle", 64'(g_done(sel)), 64'(0));
    drive(sel, 1'b1, f3, a, b, wd);
    #1;
    chk("stall_at_accept", 64'(g_stall(sel)), 64'(1));
    @(posedge clk);
    #1;
    drive(sel, 1'b0, f3, a, b, wd);
    lat = -1;
    stall_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (g_done(sel)) begin
        lat = k;
        break;
      end
      if (!g_stall(sel)) stall_ok = 1'b0;
    end
    chk("stall_through_calc", 64'(stall_ok), 64'(1));
    chk("stall_low_in_done", 64'(g_stall(sel)), 64'(0));
    chk("wreg_eq_done", 64'(g_wreg(sel)), 64'(1));
    chk("wd_out", 64'(g_wd(sel)), 64'(wd));
    res = g_res(sel);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, ra, rb;
    logic [2:0]  rf;
    int          lat;

    vecs.push_back('{"mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT1});
    vecs.push_back('{"mulh_min_min", 3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT1});
    vecs.push_back('{"mulhu_ones",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT1});
    vecs.push_back('{"mulhsu_m1_2",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT1});
    vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT1});
    vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT1});
    vecs.push_back('{"divu_100_7",   3'b101, 32'd100,        32'd7,         32'd14,        LAT1});
    vecs.push_back('{"remu_100_7",   3'b111, 32'd100,        32'd7,         32'd2,         LAT1});
    vecs.push_back('{"div_by_zero",  3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_by_zero",  3'b110, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{"div_overflow", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_overflow", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    rst = 1'b1;
    drive(1'b0, 1'b1, 3'b000, 32'd3, 32'd4, 5'd9);
    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    a_flush = 1'b0;
    b_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(a_stall), 64'(0));
    chk("rst_done", 64'(a_done), 64'(0));
    chk("rst_wreg", 64'(a_wreg), 64'(0));
    chk("rst_wd", 64'(a_wdo), 64'(0));
    chk("rst_result", 64'(a_res), 64'(0));
    a_start = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, lat);
      chk({vecs[i].name, "_result"}, 64'(res), 64'(vecs[i].exp));
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Flush in the 10th CALC cycle, then a start in the very next cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'd123, 32'd456, 5'd3);
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (10) @(negedge clk);
    a_flush = 1'b1;
    @(posedge clk);
    #1 a_flush = 1'b0;
    chk("flush_idle_stall", 64'(a_stall), 64'(0));
    chk("flush_no_done", 64'(a_done), 64'(0));
    run_op(1'b0, 3'b101, 32'd100, 32'd7, 5'd21, res, lat);
    chk("after_flush_result", 64'(res), 64'(14));
    chk("after_flush_latency", 64'(lat), 64'(LAT1));

    // Flush presented together with start must win.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'd5, 32'd6, 5'd4);
    a_flush = 1'b1;
    #1 chk("flush_prio_stall", 64'(a_stall), 64'(0));
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_flush = 1'b0;
    @(negedge clk);
    chk("flush_prio_not_busy", 64'(a_stall), 64'(0));
    chk("flush_prio_no_done", 64'(a_done), 64'(0));

    for (int n = 0; n < 40; n++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(1'b0, rf, ra, rb, 5'(n), res, lat);
      chk($sformatf("rand%0d_f3_%0d_result", n, rf), 64'(res), 64'(model(rf, ra, rb)));
      chk($sformatf("rand%0d_latency", n), 64'(lat), 64'(model_lat(rf, ra, rb)));
    end

    // Asynchronous reset in the middle of CALC.
    run_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, res, lat);
    chk("pre_reset_result", 64'(res), 64'(32'hFFFF_FFFE));
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd17);
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("result_held", 64'(a_res), 64'(32'hFFFF_FFFE));
    chk("wd_latched", 64'(a_wdo), 64'(17));
    chk("busy_mid_calc", 64'(a_stall), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_done", 64'(a_done), 64'(0));
    chk("async_rst_result", 64'(a_res), 64'(0));
    chk("async_rst_wd", 64'(a_wdo), 64'(0));
    chk("async_rst_stall", 64'(a_stall), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, res, lat);
    chk("post_reset_result", 64'(res), 64'(32'hFFFF_FFEB));
    chk("post_reset_latency", 64'(lat), 64'(LAT1));

    run_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd11, res, lat);
    chk("step4_mul_result", 64'(res), 64'(32'hFFFF_FFEB));
    chk("step4_mul_latency", 64'(lat), 64'(LAT4));
    run_op(1'b1, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, res, lat);
    chk("step4_rem_result", 64'(res), 64'(32'hFFFF_FFFF));
    chk("step4_rem_latency", 64'(lat), 64'(LAT4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
